// File: rtl/calc_pkg.sv
// Shared display definitions for the calculator result path.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package calc_pkg;

  // Active-low seven-segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Digit positions, matching the anode bit order
  localparam logic [1:0] DIG_ONES = 2'd0;
  localparam logic [1:0] DIG_TENS = 2'd1;
  localparam logic [1:0] DIG_HUND = 2'd2;
  localparam logic [1:0] DIG_SIGN = 2'd3;

  typedef enum logic {
    ST_IDLE,
    ST_CONVERT
  } conv_state_t;

  // Non-decimal nibbles never occur; they show blank rather than garbage
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter (3 BCD digits).
// Latency: WIDTH clocks from start to done; done and bcd are valid together.
// Backpressure: none; start while busy is ignored, not queued.
module bin2bcd_seq
  import calc_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [11:0]      bcd
);

  localparam int CW = $clog2(WIDTH + 1);

  conv_state_t      state;
  logic [WIDTH-1:0] shreg;
  logic [11:0]      acc;
  logic [CW-1:0]    cnt;
  logic [11:0]      adj;
  logic [WIDTH+11:0] shifted;

  // Add-3 correction on every nibble >= 5, then shift one bit in from shreg
  always_comb begin
    adj = acc;
    for (int i = 0; i < 3; i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    shifted = {adj, shreg} << 1;
  end

  // done fires combinationally on the last shift so the consumer latches
  // the result on the same edge that busy drops
  assign done = (state == ST_CONVERT) && (cnt == CW'(1));
  assign bcd  = shifted[WIDTH +: 12];

  // Conversion FSM: capture on start, shift WIDTH times, then back to idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      shreg <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            shreg <= bin;
            acc   <= '0;
            cnt   <= CW'(WIDTH);
            busy  <= 1'b1;
            state <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          acc   <= shifted[WIDTH +: 12];
          shreg <= shifted[WIDTH-1:0];
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/result_display.sv
// Captures a signed-magnitude result and scans it onto a 4-digit 7-seg display.
// Latency: WIDTH clocks load-to-display registers, one more to segment pins.
// Backpressure: load is accepted only when not busy; later loads are dropped.
module result_display
  import calc_pkg::*;
#(
  parameter int WIDTH       = 7,
  parameter int REFRESH_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             neg,
  output logic             busy,
  output logic [3:0]       an,
  output logic [6:0]       seg,
  output logic             dp
);

  localparam int RW = $clog2(REFRESH_DIV);

  logic          done;
  logic [11:0]   bcd;
  logic          neg_q;
  logic [3:0]    disp_ones;
  logic [3:0]    disp_tens;
  logic [3:0]    disp_hund;
  logic          disp_sign;
  logic [RW-1:0] rcnt;
  logic [1:0]    sel;
  logic [6:0]    seg_nxt;
  logic          nonzero;

  bin2bcd_seq #(.WIDTH(WIDTH)) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (load),
    .bin   (value),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  assign dp      = 1'b1;
  assign nonzero = (disp_ones != 4'd0) || (disp_tens != 4'd0) || (disp_hund != 4'd0);

  // Sign is latched with the accepted load; digits update only when done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q     <= 1'b0;
      disp_ones <= '0;
      disp_tens <= '0;
      disp_hund <= '0;
      disp_sign <= 1'b0;
    end else begin
      if (load && !busy) neg_q <= neg;
      if (done) begin
        disp_ones <= bcd[3:0];
        disp_tens <= bcd[7:4];
        disp_hund <= bcd[11:8];
        disp_sign <= neg_q;
      end
    end
  end

  // Pattern for the currently selected digit, with leading-zero blanking
  always_comb begin
    seg_nxt = SEG_BLANK;
    case (sel)
      DIG_ONES: seg_nxt = bcd_to_seg(disp_ones);
      DIG_TENS: seg_nxt = (disp_hund == 4'd0 && disp_tens == 4'd0) ? SEG_BLANK
                                                                    : bcd_to_seg(disp_tens);
      DIG_HUND: seg_nxt = (disp_hund == 4'd0) ? SEG_BLANK : bcd_to_seg(disp_hund);
      DIG_SIGN: seg_nxt = (disp_sign && nonzero) ? SEG_MINUS : SEG_BLANK;
      default:  seg_nxt = SEG_BLANK;
    endcase
  end

  // Refresh divider and digit select; anode and segments register together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt <= '0;
      sel  <= DIG_ONES;
      an   <= 4'b1110;
      seg  <= SEG_0;
    end else begin
      if (rcnt == RW'(REFRESH_DIV - 1)) begin
        rcnt <= '0;
        sel  <= sel + 2'd1;
      end else begin
        rcnt <= rcnt + RW'(1);
      end
      an  <= ~(4'b0001 << sel);
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_result_display.sv
module tb_result_display;

  localparam int W  = 7;
  localparam int RD = 4;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] MINUS = 7'b0111111;
  localparam logic [6:0] ZERO  = 7'b1000000;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         load  = 1'b0;
  logic         neg   = 1'b0;
  logic [W-1:0] value = '0;
  logic         busy;
  logic         dp;
  logic [3:0]   an;
  logic [6:0]   seg;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [6:0] s3;
    logic [6:0] s2;
    logic [6:0] s1;
    logic [6:0] s0;
  } disp_t;

  disp_t sb[$];

  result_display #(.WIDTH(W), .REFRESH_DIV(RD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .value (value),
    .neg   (neg),
    .busy  (busy),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return BLANK;
    endcase
  endfunction

  function automatic disp_t expect_of(input int v, input bit n);
    disp_t e;
    e.s0 = ref_seg(v % 10);
    e.s1 = (v >= 10)  ? ref_seg((v / 10) % 10) : BLANK;
    e.s2 = (v >= 100) ? ref_seg(v / 100) : BLANK;
    e.s3 = (n && v != 0) ? MINUS : BLANK;
    return e;
  endfunction

  // Drive a one-cycle load; returns at the falling edge after the sampling edge
  task automatic start_load(input int v, input bit n);
    @(negedge clk);
    value = v[W-1:0];
    neg   = n;
    load  = 1'b1;
    sb.push_back(expect_of(v, n));
    @(negedge clk);
    load = 1'b0;
  endtask

  // Counts falling-edge samples with busy high, bounded
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL busy_timeout: busy=%b after %0d cycles, want 0", busy, cycles);
    end
  endtask

  task automatic check_display(input string name);
    disp_t      e;
    logic [6:0] got [4];
    bit         seen [4];
    bit         bad_an;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_scoreboard: queue empty, want one expected entry", name);
      return;
    end
    e = sb.pop_front();
    bad_an = 1'b0;
    for (int i = 0; i < 4; i++) begin
      got[i]  = 'x;
      seen[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int c = 0; c < 6 * RD; c++) begin
      @(negedge clk);
      case (an)
        4'b1110: begin got[0] = seg; seen[0] = 1'b1; end
        4'b1101: begin got[1] = seg; seen[1] = 1'b1; end
        4'b1011: begin got[2] = seg; seen[2] = 1'b1; end
        4'b0111: begin got[3] = seg; seen[3] = 1'b1; end
        default: bad_an = 1'b1;
      endcase
    end
    total++;
    if (bad_an || !(seen[0] && seen[1] && seen[2] && seen[3])) begin
      bad++;
      $display("FAIL %s_anodes: illegal=%b seen=%b%b%b%b, want illegal=0 seen=1111",
               name, bad_an, seen[3], seen[2], seen[1], seen[0]);
    end
    total++;
    if (got[0] !== e.s0) begin
      bad++;
      $display("FAIL %s_ones: seg=%b want %b", name, got[0], e.s0);
    end
    total++;
    if (got[1] !== e.s1) begin
      bad++;
      $display("FAIL %s_tens: seg=%b want %b", name, got[1], e.s1);
    end
    total++;
    if (got[2] !== e.s2) begin
      bad++;
      $display("FAIL %s_hundreds: seg=%b want %b", name, got[2], e.s2);
    end
    total++;
    if (got[3] !== e.s3) begin
      bad++;
      $display("FAIL %s_sign: seg=%b want %b", name, got[3], e.s3);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++;
    if (an !== 4'b1110) begin bad++; $display("FAIL reset_an: got %b want 1110", an); end
    total++;
    if (seg !== ZERO) begin bad++; $display("FAIL reset_seg: got %b want %b", seg, ZERO); end
    total++;
    if (dp !== 1'b1) begin bad++; $display("FAIL reset_dp: got %b want 1", dp); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Anode rotates 1110->1101->1011->0111, RD samples each; only ones lit
  task automatic test_scan();
    logic [3:0] prev;
    logic [6:0] es;
    int         run;
    int         nruns;
    prev  = an;
    run   = 0;
    nruns = 0;
    for (int c = 0; c < 10 * RD; c++) begin
      @(negedge clk);
      es = (an == 4'b1110) ? ZERO : BLANK;
      total++;
      if (seg !== es) begin
        bad++;
        $display("FAIL scan_seg: an=%b seg=%b want %b", an, seg, es);
      end
      if (an === prev) begin
        run++;
      end else begin
        if (nruns > 0) begin
          total++;
          if (run != RD) begin
            bad++;
            $display("FAIL scan_dwell: an=%b lasted %0d want %0d", prev, run, RD);
          end
        end
        total++;
        if (an !== {prev[2:0], prev[3]}) begin
          bad++;
          $display("FAIL scan_order: an=%b after %b want %b", an, prev, {prev[2:0], prev[3]});
        end
        nruns++;
        run  = 1;
        prev = an;
      end
    end
    total++;
    if (nruns < 8) begin
      bad++;
      $display("FAIL scan_progress: transitions=%0d want >=8", nruns);
    end
  endtask

  task automatic test_basic();
    int cyc;
    start_load(127, 1'b0);
    wait_done(cyc);
    total++;
    if (cyc != W) begin
      bad++;
      $display("FAIL basic_latency: busy cycles=%0d want %0d", cyc, W);
    end
    check_display("basic127");
  endtask

  task automatic test_blanking();
    int cyc;
    start_load(5, 1'b0);
    wait_done(cyc);
    check_display("blank5");
    start_load(100, 1'b0);
    wait_done(cyc);
    check_display("blank100");
  endtask

  task automatic test_sign();
    int cyc;
    start_load(42, 1'b1);
    wait_done(cyc);
    check_display("neg42");
    start_load(0, 1'b1);
    wait_done(cyc);
    check_display("negzero");
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit rose;
    start_load(127, 1'b0);
    @(negedge clk);
    value = 7'd3;
    neg   = 1'b0;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_done(cyc);
    rose = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (busy) rose = 1'b1;
    end
    total++;
    if (rose) begin
      bad++;
      $display("FAIL b2b_requeued: busy rose=%b after done want 0", rose);
    end
    check_display("b2b");
  endtask

  task automatic test_reset_abort();
    int cyc;
    start_load(127, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    total++;
    if (an !== 4'b1110) begin bad++; $display("FAIL abort_an: got %b want 1110", an); end
    total++;
    if (seg !== ZERO) begin bad++; $display("FAIL abort_seg: got %b want %b", seg, ZERO); end
    @(negedge clk);
    rst_n = 1'b1;
    start_load(9, 1'b0);
    wait_done(cyc);
    total++;
    if (cyc != W) begin
      bad++;
      $display("FAIL abort_latency: busy cycles=%0d want %0d", cyc, W);
    end
    check_display("after_abort9");
  endtask

  initial begin
    test_reset();
    test_scan();
    test_basic();
    test_blanking();
    test_sign();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
